sfp_clip_monitor: RTL and testbench



---
 rtl/sfp_clip_monitor.sv | 118 +++++++++++
 tb/tb_sfp_clip_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sfp_clip_monitor.sv
// Per-window clip statistics for a sample-valid sfp stream: clip count, peak |in|,
// sticky clip flag and a hysteretic over-clip alarm evaluated at each window close.
module sfp_clip_monitor #(
    parameter int WIN_LEN = 1024,
    parameter int CNT_W   = 16,
    parameter int HOLD    = 4,
    parameter int WL      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WL-1:0]    in,
    input  logic             in_valid,
    input  logic             clipping,
    input  logic             clear,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] win_cnt,
    output logic [WL-1:0]    win_peak,
    output logic             win_done,
    output logic             alarm,
    output logic             sticky
);
    // state | meaning
    // OFF   | alarm low; waiting for a window with count >= thresh
    // ON    | alarm high; hold_cnt counts consecutive clean windows
    typedef enum logic {OFF = 1'b0, ON = 1'b1} alarm_state_t;

    localparam int SMP_W  = $clog2(WIN_LEN);
    localparam int HOLD_W = $clog2(HOLD + 1);

    alarm_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [SMP_W-1:0]  smp_cnt;
    logic [CNT_W-1:0]  acc_cnt, cnt_next;
    logic [WL-1:0]     acc_peak, peak_next, mag;
    logic              win_close;

    // Two's complement negate at full width: the most negative code lands on 2^(WL-1).
    assign mag       = in[WL-1] ? (~in + 1'b1) : in;
    assign cnt_next  = (clipping && (acc_cnt != {CNT_W{1'b1}})) ? acc_cnt + 1'b1 : acc_cnt;
    assign peak_next = (mag > acc_peak) ? mag : acc_peak;
    assign win_close = in_valid && (smp_cnt == SMP_W'(WIN_LEN - 1));
    assign hold_inc  = hold_q + 1'b1;
    assign alarm     = (state_q == ON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt  <= '0;
            acc_cnt  <= '0;
            acc_peak <= '0;
            win_cnt  <= '0;
            win_peak <= '0;
            win_done <= 1'b0;
            sticky   <= 1'b0;
        end else if (clear) begin
            smp_cnt  <= '0;
            acc_cnt  <= '0;
            acc_peak <= '0;
            win_cnt  <= '0;
            win_peak <= '0;
            win_done <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (in_valid) begin
                if (clipping) begin
                    sticky <= 1'b1;
                end
                if (win_close) begin
                    win_cnt  <= cnt_next;
                    win_peak <= peak_next;
                    win_done <= 1'b1;
                    acc_cnt  <= '0;
                    acc_peak <= '0;
                    smp_cnt  <= '0;
                end else begin
                    acc_cnt  <= cnt_next;
                    acc_peak <= peak_next;
                    smp_cnt  <= smp_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            hold_q  <= '0;
        end else if (clear) begin
            state_q <= OFF;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (win_close) begin
            if (thresh == '0) begin
                state_d = OFF;
                hold_d  = '0;
            end else if (cnt_next >= thresh) begin
                state_d = ON;
                hold_d  = '0;
            end else if (state_q == ON) begin
                if (hold_inc == HOLD_W'(HOLD)) begin
                    state_d = OFF;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfp_clip_monitor.sv
// Randomized and directed bench for sfp_clip_monitor against a window-level reference
// model (WIN_LEN=8, CNT_W=3, HOLD=2, WL=8).
module tb_sfp_clip_monitor;
    localparam int WIN_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int HOLD    = 2;
    localparam int WL      = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WL-1:0]    in_s;
    logic             in_valid;
    logic             clipping;
    logic             clear;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W-1:0] win_cnt;
    logic [WL-1:0]    win_peak;
    logic             win_done;
    logic             alarm;
    logic             sticky;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_n, m_acc, m_peak, m_wcnt, m_wpeak, m_done, m_sticky, m_on, m_clean;

    sfp_clip_monitor #(
        .WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .HOLD(HOLD), .WL(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .clipping(clipping),
        .clear(clear), .thresh(thresh), .win_cnt(win_cnt), .win_peak(win_peak),
        .win_done(win_done), .alarm(alarm), .sticky(sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int absv(input logic [WL-1:0] x);
        int u;
        u = int'(x);
        return x[WL-1] ? (1 << WL) - u : u;
    endfunction

    task automatic model_reset();
        m_n = 0; m_acc = 0; m_peak = 0; m_wcnt = 0; m_wpeak = 0;
        m_done = 0; m_sticky = 0; m_on = 0; m_clean = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".win_cnt"},  int'(win_cnt),  m_wcnt);
        check({tag, ".win_peak"}, int'(win_peak), m_wpeak);
        check({tag, ".win_done"}, int'(win_done), m_done);
        check({tag, ".alarm"},    int'(alarm),    m_on);
        check({tag, ".sticky"},   int'(sticky),   m_sticky);
    endtask

    // One clock: drive, let the edge happen, advance the model, check at the falling edge.
    task automatic step(input string tag, input bit v, input bit c,
                        input logic [WL-1:0] x, input bit clr);
        int t;
        in_valid = v; clipping = c; in_s = x; clear = clr;
        @(posedge clk);
        t = int'(thresh);
        m_done = 0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (c) begin
                m_sticky = 1;
                if (m_acc < CNT_MAX) m_acc++;
            end
            if (absv(x) > m_peak) m_peak = absv(x);
            m_n++;
            if (m_n == WIN_LEN) begin
                m_wcnt = m_acc; m_wpeak = m_peak; m_done = 1;
                if (t == 0) begin
                    m_on = 0; m_clean = 0;
                end else if (m_acc >= t) begin
                    m_on = 1; m_clean = 0;
                end else if (m_on == 1) begin
                    m_clean++;
                    if (m_clean == HOLD) begin m_on = 0; m_clean = 0; end
                end
                m_acc = 0; m_peak = 0; m_n = 0;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Full window of valid samples; bit k of clipmask marks sample k+1 as clipped.
    task automatic run_win(input string tag, input logic [7:0] clipmask, input bit gaps);
        logic [WL-1:0] r;
        for (int k = 0; k < WIN_LEN; k++) begin
            r = WL'($urandom);
            step(tag, 1'b1, clipmask[k], r, 1'b0);
            if (gaps) step(tag, 1'b0, 1'b1, WL'($urandom), 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_s = '0; in_valid = 1'b0; clipping = 1'b0; clear = 1'b0; thresh = '0;
        model_reset();
        #23;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 8 back-to-back samples, clips on samples 3 and 6, thresh 2
        thresh = 3'd2;
        run_win("clip2", 8'b0010_0100, 1'b0);
        check("clip2.win_cnt_final", int'(win_cnt), 2);
        check("clip2.alarm_final", int'(alarm), 1);

        // alternate-cycle valid, clipping high on the invalid cycles
        run_win("gaps", 8'b0000_0001, 1'b1);

        // hysteresis: clean, bad(3), clean, clean
        run_win("hyst_clean1", 8'h00, 1'b0);
        run_win("hyst_bad",    8'b0100_1001, 1'b0);
        run_win("hyst_clean2", 8'h00, 1'b0);
        run_win("hyst_clean3", 8'h00, 1'b0);
        check("hyst.alarm_dropped", int'(alarm), 0);

        // peak including the most negative code, then a window with smaller peak
        step("peak", 1'b1, 1'b0, 8'd100, 1'b0);
        step("peak", 1'b1, 1'b0, 8'hCE, 1'b0);
        step("peak", 1'b1, 1'b0, 8'h80, 1'b0);
        for (int k = 0; k < WIN_LEN - 3; k++) step("peak", 1'b1, 1'b0, 8'd7, 1'b0);
        check("peak.win_peak_128", int'(win_peak), 128);
        step("peak2", 1'b1, 1'b0, 8'd100, 1'b0);
        step("peak2", 1'b1, 1'b0, 8'hCE, 1'b0);
        for (int k = 0; k < WIN_LEN - 2; k++) step("peak2", 1'b1, 1'b0, 8'd0, 1'b0);
        check("peak2.win_peak_100", int'(win_peak), 100);

        // saturation: every sample clips, count pins at 7
        run_win("sat", 8'hFF, 1'b0);
        check("sat.win_cnt_7", int'(win_cnt), CNT_MAX);

        // clear with a valid clip mid-window; next window needs a full WIN_LEN
        for (int k = 0; k < 3; k++) step("clr_pre", 1'b1, 1'b1, 8'd5, 1'b0);
        step("clr", 1'b1, 1'b1, 8'd120, 1'b1);
        check("clr.sticky_0", int'(sticky), 0);
        run_win("clr_post", 8'h00, 1'b0);

        // asynchronous reset mid-window
        thresh = 3'd1;
        for (int k = 0; k < 4; k++) step("rst_pre", 1'b1, 1'b1, 8'd9, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        run_win("rst_post", 8'b0000_0010, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1200; i++) begin
            if (i % 40 == 0) thresh = CNT_W'($urandom_range(0, CNT_MAX));
            step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                 WL'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
